// File: rtl/mem_port_arbiter.sv
// Two-master (fetch, data) to one-slave SRAM-bus arbiter; data-first with a fetch starvation guard.
// Zero-latency grant path in IDLE, one transaction outstanding; the non-owner waits with req held.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_dcached,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_dcached,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  state_t          state_q;
  owner_t          owner_q;
  logic [CW-1:0]   starve_cnt_q;

  logic any_req;
  logic starved;
  logic win_data;
  logic sel_data;
  logic addr_phase;
  logic req_sel;
  logic fwd_aok;
  logic fwd_dok;

  // Arbitration is only meaningful in IDLE; afterwards the latched owner steers everything.
  always_comb begin
    any_req    = inst_req | data_req;
    starved    = (starve_cnt_q == CW'(STARVE_LIMIT));
    win_data   = data_req && !(inst_req && starved);
    sel_data   = (state_q == IDLE) ? win_data : (owner_q == OWN_DATA);
    addr_phase = ((state_q == IDLE) && any_req) || (state_q == WAIT_ADDR);
    req_sel    = sel_data ? data_req : inst_req;
  end

  always_comb begin
    mem_req     = addr_phase && req_sel;
    mem_wr      = 1'b0;
    mem_size    = 2'd0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_dcached = 1'b0;
    if (mem_req) begin
      if (sel_data) begin
        mem_wr      = data_wr;
        mem_size    = data_size;
        mem_addr    = data_addr;
        mem_wdata   = data_wdata;
        mem_dcached = data_dcached;
      end else begin
        mem_wr      = inst_wr;
        mem_size    = inst_size;
        mem_addr    = inst_addr;
        mem_wdata   = inst_wdata;
      end
    end
  end

  // A data_ok without addr_ok during the address phase is a slave error and is dropped.
  always_comb begin
    fwd_aok      = addr_phase && mem_addr_ok;
    fwd_dok      = mem_data_ok && ((addr_phase && mem_addr_ok) || (state_q == WAIT_DATA));
    inst_addr_ok = fwd_aok && !sel_data;
    inst_data_ok = fwd_dok && !sel_data;
    data_addr_ok = fwd_aok && sel_data;
    data_data_ok = fwd_dok && sel_data;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= OWN_DATA;
      starve_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q <= win_data ? OWN_DATA : OWN_INST;
            if (win_data && inst_req) begin
              if (!starved) starve_cnt_q <= starve_cnt_q + CW'(1);
            end else begin
              starve_cnt_q <= '0;
            end
            if (mem_addr_ok && mem_data_ok) state_q <= IDLE;
            else if (mem_addr_ok)           state_q <= WAIT_DATA;
            else                            state_q <= WAIT_ADDR;
          end
        end
        WAIT_ADDR: begin
          if (mem_addr_ok) state_q <= mem_data_ok ? IDLE : WAIT_DATA;
        end
        WAIT_DATA: begin
          if (mem_data_ok) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master, one-slave arbiter for the CPU's SRAM-like memory bus. It shares a single downstream port between the instruction-fetch requester and the data requester, which is the store-buffer output. Data has priority, with a starvation guard for fetch. One transaction is in flight at a time. Each response is routed back to the master that issued the request. The block sits between the store buffer / fetch unit and the AXI bridge or cache.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while inst_req is pending before inst is forced to win; legal range 1..15.
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req / inst_wr / inst_size / inst_addr / inst_wdata  in  1/1/2/32/32  fetch-side request.
- inst_rdata  out  32  read data to fetch.
- inst_addr_ok / inst_data_ok  out  1/1  handshake to fetch.
- data_req / data_wr / data_size / data_addr / data_wdata  in  1/1/2/32/32  data-side request.
- data_dcached  in  1  cacheability attribute of the data request.
- data_rdata  out  32  read data to data side.
- data_addr_ok / data_data_ok  out  1/1  handshake to data side.
- mem_req / mem_wr / mem_size / mem_addr / mem_wdata  out  1/1/2/32/32  downstream request.
- mem_dcached  out  1  data_dcached when data owns the port; 0 when inst owns it.
- mem_rdata  in  32  downstream read data.
- mem_addr_ok / mem_data_ok  in  1/1  downstream handshake.

## Operation
- State register: IDLE, WAIT_ADDR, WAIT_DATA. Owner register: INST or DATA. Starvation counter starve_cnt, width $clog2(STARVE_LIMIT+1).
- Arbitration happens in IDLE only, and is combinational:
  - If exactly one request is high, that master wins.
  - If both are high, DATA wins unless starve_cnt == STARVE_LIMIT, in which case INST wins.
- IDLE: the winner's request fields pass straight to mem_* in the same cycle (zero added latency). mem_req = 0 when there is no request.
- IDLE with a winner:
  - mem_addr_ok=1 and mem_data_ok=1: complete; stay IDLE.
  - mem_addr_ok=1 only: go to WAIT_DATA.
  - neither: go to WAIT_ADDR.
  - The owner is latched in all three cases.
- WAIT_ADDR: mem_* driven from the latched owner's inputs.
  - The owner must hold req and fields stable until addr_ok (bus rule).
  - The other master is not considered, even if it asserts req.
  - On mem_addr_ok, go to WAIT_DATA, or to IDLE if mem_data_ok is also high.
- WAIT_DATA: mem_req = 0. On mem_data_ok, go to IDLE.
- Routing:
  - mem_addr_ok and mem_data_ok are forwarded only to the current owner. In IDLE, the current owner is the combinational winner.
  - The non-owner's addr_ok and data_ok are 0.
  - inst_rdata = data_rdata = mem_rdata, unconditionally.
- mem_data_ok while in WAIT_ADDR with no mem_addr_ok is a slave protocol error. It is ignored: no state change and nothing forwarded.
- Starvation counter, updated at each grant (the cycle the owner is latched from IDLE):
  - DATA granted while inst_req=1: saturating increment.
  - DATA granted while inst_req=0: clear to 0.
  - INST granted: clear to 0.

## Timing
- Reset (resetn=0, asynchronous): state=IDLE, owner=DATA, starve_cnt=0, immediately.
  - With both reqs low, every output is 0 (rdata follows mem_rdata).
  - Reset mid-transaction abandons it. The downstream slave is reset on the same net.
- Minimum transaction: 1 cycle, with addr_ok and data_ok in the same IDLE cycle.
- Back-to-back: after a data_ok cycle returns to IDLE, a new grant is possible on the very next cycle. There is no bubble beyond the state transition.
- The arbitration decision is frozen from the grant cycle until data_ok. Request changes by the non-owner have no effect during that window.
- Throughput: at most one transaction outstanding; addr_ok for a new request never precedes data_ok of the previous one.

## Test plan
- Single data write. data_req=1, wr=1, addr=0x1000_0010, wdata=0xDEAD_BEEF, dcached=1; slave gives addr_ok in cycle 0 and data_ok in cycle 2.
  - Required: mem_* mirror the request in cycle 0; data_addr_ok=1 in cycle 0; data_data_ok=1 in cycle 2; inst_* handshakes 0 throughout; mem_dcached=1.
- Conflict. Both reqs high in IDLE with starve_cnt=0.
  - Required: DATA granted; inst_addr_ok stays 0 until data's data_ok; INST is granted on the next cycle.
- Starvation. STARVE_LIMIT=4; inst_req held high; data issues continuous requests.
  - Required: data wins exactly 4 grants, then INST is granted on the 5th arbitration; starve_cnt reads 0 afterward.
- Addr stall. Slave holds mem_addr_ok=0 for 3 cycles after a data read of 0x0000_0040; inst_req rises in cycle 1.
  - Required: mem_addr stays 0x0000_0040 through WAIT_ADDR; no inst forwarding; data_data_ok is the only data_ok seen.
- Combined handshake. Slave asserts addr_ok and data_ok in the same cycle for an inst read, with mem_rdata=0x2400_0001.
  - Required: inst_addr_ok=inst_data_ok=1 that cycle; inst_rdata=0x2400_0001; state stays IDLE.
- Async reset in WAIT_DATA.
  - Required: state returns to IDLE without waiting for clk; all handshakes 0; a fresh request after reset release completes normally.
